pwm_audio_out: RTL and testbench
================================

Name: pwm_audio_out

Overview:
- Output end of the audio path: takes 8-bit signed PCM samples from the recorder/tone logic and drives the 1-bit headphone/amp pin.
- Generates the sample-rate request strobe that upstream logic uses as its `ready_in` step.
- Latches one sample per sample period and converts it to a glitch-free 8-bit PWM waveform.
- A gain-ramp FSM fades the output in and out on enable/disable to avoid clicks.

Parameters:
- SAMPLE_DIV, 2083: clock cycles per sample period (100 MHz / 2083 ≈ 48 kHz); legal range 16..65535.
- RAMP_MAX, 256: full-scale gain; one ramp step per sample period, so a full ramp takes 256 samples.

Ports:
- clk_in  input  1  100 MHz system clock
- rst_in  input  1  synchronous active-high reset
- enable_in  input  1  1 = play, 0 = fade out and shut down
- sample_in  input  8  signed PCM sample (two's complement)
- sample_valid_in  input  1  one-cycle strobe, sample_in valid
- sample_req_out  output  1  one-cycle strobe each sample period (feeds upstream ready_in)
- audio_out  output  1  PWM (or DSM) audio bit to the output filter
- audio_sd_out  output  1  amplifier enable, 1 = amp on
- underrun_out  output  1  sticky; set when a request period closes without sample_valid_in
- state_out  output  2  FSM state: 0 OFF, 1 RAMP_UP, 2 PLAY, 3 RAMP_DOWN

Behaviour:
- Reset:
  - All outputs 0; state OFF; gain 0; held sample 0; duty_q 128.
  - Sample counter 0; PWM counter 0.
  - Reset mid-operation has identical effect, with no partial ramp retained.
- Sample timing:
  - 16-bit counter runs 0..SAMPLE_DIV-1 and wraps.
  - sample_req_out = 1 for exactly the cycle where counter == SAMPLE_DIV-1.
  - The strobe runs in every state except during reset.
- Sample latch:
  - On sample_valid_in, held_sample <= sample_in. The last valid in a period wins.
  - A valid arriving in the same cycle as sample_req_out counts toward the period that is closing.
  - If no valid arrived since the previous req when req fires, set underrun_out and keep held_sample.
  - underrun_out clears only on reset. Underruns are not flagged while in OFF.
- Gain:
  - g is 9-bit, range 0..RAMP_MAX.
  - scaled = (held_sample * g) >>> 8, signed 17-bit product, arithmetic shift, saturated to -128..127.
  - target_duty = scaled + 128, giving unsigned 0..255.
- PWM:
  - 8-bit counter pwm_cnt runs freely 0..255.
  - audio_out = (pwm_cnt < duty_q), registered.
  - duty_q <= target_duty only in the cycle where pwm_cnt == 255, so each period is glitch-free.
  - duty 0 gives constant low; duty 255 gives high for 255 of 256 cycles.
  - In OFF, audio_out is forced to 0.
- FSM, evaluated on sample_req_out strobes unless stated otherwise:
  - OFF: audio_sd_out = 0, g = 0. When enable_in = 1 (checked every cycle), go to RAMP_UP and set audio_sd_out = 1 the next cycle.
  - RAMP_UP: g += 1 per req. When g reaches RAMP_MAX, go to PLAY. If enable_in = 0, go to RAMP_DOWN immediately, keeping the current g.
  - PLAY: g = RAMP_MAX. If enable_in = 0, go to RAMP_DOWN.
  - RAMP_DOWN: g -= 1 per req. When g reaches 0, go to OFF (audio_sd_out = 0). If enable_in = 1, go to RAMP_UP keeping the current g.
  - enable_in toggling between strobes takes effect on the next cycle; there is no ramp reset on reversal.
- Latency: sample_valid_in to duty_q update is at most 256 + 2 cycles (next PWM period boundary).

Optional Feature:
- Macro: PWM_AUDIO_DSM_EN.
- Defined: the PWM comparator is replaced by a first-order delta-sigma modulator.
  - 9-bit accumulator: acc <= acc[7:0] + duty_q every cycle.
  - audio_out = acc[8].
  - duty_q updates on sample_req_out instead of at pwm_cnt == 255.
  - In OFF, the accumulator is held at 0 and audio_out is forced to 0.
- Undefined: PWM as described; no accumulator is present.

Test Plan:
- Reset, SAMPLE_DIV=16 -> all outputs 0, state_out=0; sample_req_out pulses every 16 cycles with its first pulse at cycle 15 after reset release; underrun_out stays 0 while in OFF.
- enable_in=1, sample 0x7F supplied every req -> state goes 1→2 after 256 reqs; final duty_q=255; audio_out high 255 of 256 cycles; audio_sd_out=1 from cycle 1.
- In PLAY with samples 0x80, then 0x00 -> duty_q=0 with audio_out constant 0, then duty_q=128 with 128/256 high; duty_q changes only when pwm_cnt==255.
- Drop enable_in in PLAY -> g decreases 1 per req; state 3 then 0 after 256 reqs; audio_sd_out=0 and audio_out=0 in OFF.
- Re-raise enable_in at g=100 during RAMP_DOWN -> state 1, g continues upward from 100, reaches PLAY after 156 reqs.
- Omit sample_valid_in for one period in PLAY -> underrun_out=1 and stays 1; held sample unchanged; synchronous reset clears it. With PWM_AUDIO_DSM_EN defined and duty 64 -> audio_out density 64/256 ±1 over 256 cycles.

Source files
------------

// File: rtl/pwm_audio_out.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | pwm_audio_out: 8-bit PCM to 1-bit PWM (or DSM with PWM_AUDIO_DSM_EN),     |
// | with sample-rate request strobe, underrun flag and click-free gain ramp.  |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module pwm_audio_out #(
    parameter int unsigned SAMPLE_DIV = 2083,
    parameter int unsigned RAMP_MAX   = 256
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       enable_in,
    input  logic [7:0] sample_in,
    input  logic       sample_valid_in,
    output logic       sample_req_out,
    output logic       audio_out,
    output logic       audio_sd_out,
    output logic       underrun_out,
    output logic [1:0] state_out
);

    typedef enum logic [1:0] {
        ST_OFF       = 2'd0,
        ST_RAMP_UP   = 2'd1,
        ST_PLAY      = 2'd2,
        ST_RAMP_DOWN = 2'd3
    } state_t;

    localparam logic [15:0] c_DIV_LAST = 16'(SAMPLE_DIV - 1);
    localparam logic [8:0]  c_GAIN_MAX = 9'(RAMP_MAX);

    state_t      state_q, state_d;
    logic [15:0] div_cnt_q, div_cnt_d;
    logic [8:0]  gain_q, gain_d;
    logic [7:0]  held_q, held_d;
    logic        got_q, got_d;
    logic        underrun_q, underrun_d;
    logic [7:0]  duty_q, duty_d;

    logic               w_req;
    logic signed [16:0] w_held_ext;
    logic signed [16:0] w_gain_ext;
    logic signed [16:0] w_product;
    logic signed [16:0] w_shift;
    logic [7:0]         w_sat;
    logic [7:0]         w_target;

    assign w_req = (div_cnt_q == c_DIV_LAST);

    // Gain scaling: signed sample times unsigned gain, floor-shifted by 8.
    assign w_held_ext = {{9{held_q[7]}}, held_q};
    assign w_gain_ext = {8'd0, gain_q};
    assign w_product  = w_held_ext * w_gain_ext;
    assign w_shift    = w_product >>> 8;

    always_comb begin
        w_sat = w_shift[7:0];
        if (w_shift > 17'sd127) begin
            w_sat = 8'h7F;
        end else if (w_shift < -17'sd128) begin
            w_sat = 8'h80;
        end
    end

    // Offset-binary: flipping the sign bit adds 128.
    assign w_target = w_sat ^ 8'h80;

    always_comb begin
        div_cnt_d  = w_req ? 16'd0 : div_cnt_q + 16'd1;
        held_d     = sample_valid_in ? sample_in : held_q;
        got_d      = w_req ? 1'b0 : (got_q | sample_valid_in);
        underrun_d = underrun_q |
                     (w_req && (state_q != ST_OFF) && !got_q && !sample_valid_in);
    end

    always_comb begin
        state_d = state_q;
        gain_d  = gain_q;
        unique case (state_q)
            ST_OFF: begin
                gain_d = 9'd0;
                if (enable_in) state_d = ST_RAMP_UP;
            end
            ST_RAMP_UP: begin
                if (!enable_in) begin
                    state_d = ST_RAMP_DOWN;
                end else if (gain_q >= c_GAIN_MAX) begin
                    state_d = ST_PLAY;
                end else if (w_req) begin
                    gain_d = gain_q + 9'd1;
                    if (gain_q + 9'd1 == c_GAIN_MAX) state_d = ST_PLAY;
                end
            end
            ST_PLAY: begin
                gain_d = c_GAIN_MAX;
                if (!enable_in) state_d = ST_RAMP_DOWN;
            end
            ST_RAMP_DOWN: begin
                if (enable_in) begin
                    state_d = ST_RAMP_UP;
                end else if (gain_q == 9'd0) begin
                    state_d = ST_OFF;
                end else if (w_req) begin
                    gain_d = gain_q - 9'd1;
                    if (gain_q == 9'd1) state_d = ST_OFF;
                end
            end
            default: state_d = ST_OFF;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= ST_OFF;
            div_cnt_q  <= 16'd0;
            gain_q     <= 9'd0;
            held_q     <= 8'd0;
            got_q      <= 1'b0;
            underrun_q <= 1'b0;
            duty_q     <= 8'd128;
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            gain_q     <= gain_d;
            held_q     <= held_d;
            got_q      <= got_d;
            underrun_q <= underrun_d;
            duty_q     <= duty_d;
        end
    end

`ifdef PWM_AUDIO_DSM_EN
    logic [8:0] acc_q, acc_d;

    always_comb begin
        duty_d = w_req ? w_target : duty_q;
        acc_d  = (state_q == ST_OFF) ? 9'd0 : {1'b0, acc_q[7:0]} + {1'b0, duty_q};
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            acc_q <= 9'd0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign audio_out = acc_q[8] & (state_q != ST_OFF);
`else
    logic [7:0] pwm_cnt_q;
    logic       audio_q, audio_d;

    // Duty only moves at the period boundary so no PWM period is truncated.
    always_comb begin
        duty_d  = (pwm_cnt_q == 8'hFF) ? w_target : duty_q;
        audio_d = (state_q != ST_OFF) && (pwm_cnt_q < duty_q);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pwm_cnt_q <= 8'd0;
            audio_q   <= 1'b0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + 8'd1;
            audio_q   <= audio_d;
        end
    end

    assign audio_out = audio_q;
`endif

    assign sample_req_out = w_req;
    assign audio_sd_out   = (state_q != ST_OFF);
    assign underrun_out   = underrun_q;
    assign state_out      = state_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_audio_out.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pwm_audio_out: scoreboard bench for pwm_audio_out at SAMPLE_DIV=16.    |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_pwm_audio_out;

    localparam int DIV = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       valid;
    logic [7:0] sample;
    logic       sample_req_out;
    logic       audio_out;
    logic       audio_sd_out;
    logic       underrun_out;
    logic [1:0] state_out;

    pwm_audio_out #(.SAMPLE_DIV(DIV), .RAMP_MAX(256)) dut (
        .clk_in          (clk),
        .rst_in          (rst),
        .enable_in       (en),
        .sample_in       (sample),
        .sample_valid_in (valid),
        .sample_req_out  (sample_req_out),
        .audio_out       (audio_out),
        .audio_sd_out    (audio_sd_out),
        .underrun_out    (underrun_out),
        .state_out       (state_out)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input int act, input int exp);
        n_total++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference: scaled = floor(sample * g / 256), saturated, offset by 128.
    function automatic int exp_duty(input logic [7:0] h, input int g);
        int p;
        int s;
        p = $signed(h) * g;
        s = (p >= 0) ? p / 256 : -((-p + 255) / 256);
        if (s > 127) s = 127;
        if (s < -128) s = -128;
        return s + 128;
    endfunction

    // Behavioural model of the block, advanced on the same edges as the DUT.
    int         c;
    logic [1:0] m_state;
    int         m_g;
    logic [7:0] m_held;
    logic       m_got;
    logic       m_und;
    logic       win_off;
    int         sb[$];
    logic       m_req;

    assign m_req = ((c % DIV) == DIV - 1);

    always @(posedge clk) begin
        if (rst) begin
            c       <= 0;
            m_state <= 2'd0;
            m_g     <= 0;
            m_held  <= 8'h00;
            m_got   <= 1'b0;
            m_und   <= 1'b0;
            win_off <= 1'b1;
            sb.delete();
            sb.push_back(128);
        end else begin
            c       <= c + 1;
            m_held  <= valid ? sample : m_held;
            m_got   <= m_req ? 1'b0 : (m_got | valid);
            if (m_req && m_state != 2'd0 && !m_got && !valid) m_und <= 1'b1;
            win_off <= (((c % 256) == 0) ? 1'b0 : win_off) | (m_state == 2'd0);
            if ((c % 256) == 255) sb.push_back(exp_duty(m_held, m_g));
            case (m_state)
                2'd0: if (en) m_state <= 2'd1;
                2'd1: begin
                    if (!en) m_state <= 2'd3;
                    else if (m_req) begin
                        m_g <= m_g + 1;
                        if (m_g + 1 == 256) m_state <= 2'd2;
                    end
                end
                2'd2: if (!en) m_state <= 2'd3;
                default: begin
                    if (en) m_state <= 2'd1;
                    else if (m_req) begin
                        m_g <= m_g - 1;
                        if (m_g == 1) m_state <= 2'd0;
                    end
                end
            endcase
        end
    end

    // Monitor: high-count per PWM period against the scoreboard head.
    int hi_cnt;
    always @(negedge clk) begin
        if (!rst && c > 0) begin
            if ((c % 256) == 1) hi_cnt <= int'(audio_out);
            else hi_cnt <= hi_cnt + int'(audio_out);
`ifndef PWM_AUDIO_DSM_EN
            if ((c % 256) == 0) begin
                if (sb.size() == 0) begin
                    chk("sb_empty", 0, 1);
                end else begin
                    if (!win_off) chk("pwm_window", hi_cnt + int'(audio_out), sb[0]);
                    void'(sb.pop_front());
                end
            end
`endif
            if (c < 64) chk("req_timing", int'(sample_req_out), int'((c % DIV) == DIV - 1));
            if (m_req) begin
                chk("state_vs_model", int'(state_out), int'(m_state));
                chk("underrun_vs_model", int'(underrun_out), int'(m_und));
            end
        end
    end

    // Upstream source: answers each request strobe when feeding is enabled.
    logic       feed;
    logic [7:0] cur;
    initial begin
        valid  = 1'b0;
        sample = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            valid  = feed && sample_req_out && !rst;
            sample = cur;
        end
    end

    task automatic wait_reqs(input int n);
        int got = 0;
        int t   = 0;
        while (got < n && t < (n + 4) * DIV) begin
            @(negedge clk);
            t++;
            if (sample_req_out) got++;
        end
        if (got < n) chk("req_timeout", got, n);
    endtask

    initial begin
        rst  = 1'b1;
        en   = 1'b0;
        feed = 1'b0;
        cur  = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_audio", int'(audio_out), 0);
        chk("rst_sd", int'(audio_sd_out), 0);
        chk("rst_underrun", int'(underrun_out), 0);
        chk("rst_state", int'(state_out), 0);
        chk("rst_req", int'(sample_req_out), 0);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("off_underrun", int'(underrun_out), 0);
        chk("off_state", int'(state_out), 0);

        // Fade in with full-scale positive samples.
        cur  = 8'h7F;
        feed = 1'b1;
        en   = 1'b1;
        @(negedge clk);
        chk("ru_state", int'(state_out), 1);
        chk("ru_sd", int'(audio_sd_out), 1);
        wait_reqs(255);
        @(negedge clk);
        chk("ru_255_state", int'(state_out), 1);
        wait_reqs(1);
        @(negedge clk);
        chk("ru_256_state", int'(state_out), 2);
        repeat (600) @(negedge clk);

        // Full-scale negative then midscale.
        cur = 8'h80;
        repeat (800) @(negedge clk);
        cur = 8'h00;
        repeat (800) @(negedge clk);
        chk("play_underrun", int'(underrun_out), 0);

        // Fade out, reverse at g=100, climb back.
        cur = 8'h7F;
        repeat (300) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        chk("rd_state", int'(state_out), 3);
        wait_reqs(156);
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        chk("rev_state", int'(state_out), 1);
        wait_reqs(155);
        @(negedge clk);
        chk("rev_155_state", int'(state_out), 1);
        wait_reqs(1);
        @(negedge clk);
        chk("rev_156_state", int'(state_out), 2);

        // Full fade out to OFF.
        en = 1'b0;
        wait_reqs(255);
        @(negedge clk);
        chk("rd_255_state", int'(state_out), 3);
        chk("rd_255_sd", int'(audio_sd_out), 1);
        wait_reqs(1);
        @(negedge clk);
        chk("off2_state", int'(state_out), 0);
        chk("off2_sd", int'(audio_sd_out), 0);
        @(negedge clk);
        chk("off2_audio", int'(audio_out), 0);
        feed = 1'b0;
        repeat (100) @(negedge clk);
        chk("off2_underrun", int'(underrun_out), 0);

        // Play at sample 0x40, then drop one sample.
        cur  = 8'h40;
        feed = 1'b1;
        en   = 1'b1;
        wait_reqs(256);
        @(negedge clk);
        chk("play2_state", int'(state_out), 2);
        repeat (600) @(negedge clk);
`ifdef PWM_AUDIO_DSM_EN
        begin
            int dens = 0;
            cur = 8'hC0;
            repeat (3 * DIV) @(negedge clk);
            for (int i = 0; i < 256; i++) begin
                @(negedge clk);
                dens += int'(audio_out);
            end
            chk("dsm_density", (dens >= 63 && dens <= 65) ? 64 : dens, 64);
            cur = 8'h40;
            repeat (3 * DIV) @(negedge clk);
        end
`endif
        feed = 1'b0;
        wait_reqs(1);
        @(negedge clk);
        chk("underrun_set", int'(underrun_out), 1);
        feed = 1'b1;
        repeat (600) @(negedge clk);
        chk("underrun_sticky", int'(underrun_out), 1);

        // Mid-operation reset.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst2_underrun", int'(underrun_out), 0);
        chk("rst2_state", int'(state_out), 0);
        chk("rst2_sd", int'(audio_sd_out), 0);
        chk("rst2_audio", int'(audio_out), 0);
        rst = 1'b0;
        wait_reqs(1);
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        chk("rst2_rd_state", int'(state_out), 3);
        wait_reqs(1);
        @(negedge clk);
        chk("rst2_off_state", int'(state_out), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
